// File: rtl/tt_dfd_capture_ctrl.sv
// Trigger-qualified sampling controller feeding the debug capture register stage.
// Produces a one-cycle capture enable plus registered sample data, with arm/trigger/post-count control.
module tt_dfd_capture_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned DECIM_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm_i,
  input  logic                   disarm_i,
  input  logic                   trigger_i,
  input  logic [CNT_WIDTH-1:0]   post_count_i,
  input  logic [DECIM_WIDTH-1:0] decim_i,
  input  logic [WIDTH-1:0]       in,
  output logic                   cap_en_o,
  output logic [WIDTH-1:0]       cap_data_o,
  output logic [1:0]             state_o,
  output logic                   done_o,
  output logic                   trig_seen_o,
  output logic [CNT_WIDTH-1:0]   sample_cnt_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [DECIM_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
  logic                 trig_seen_q, trig_seen_d;
  logic                 cap_en_q, cap_en_d;
  logic [WIDTH-1:0]     cap_data_q, cap_data_d;
  logic                 done_q, done_d;

  logic running;
  logic strobe;
  logic cap_take;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      dec_cnt_q    <= '0;
      remaining_q  <= '0;
      sample_cnt_q <= '0;
      trig_seen_q  <= 1'b0;
      cap_en_q     <= 1'b0;
      cap_data_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_cnt_q    <= dec_cnt_d;
      remaining_q  <= remaining_d;
      sample_cnt_q <= sample_cnt_d;
      trig_seen_q  <= trig_seen_d;
      cap_en_q     <= cap_en_d;
      cap_data_q   <= cap_data_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    dec_cnt_d    = dec_cnt_q;
    remaining_d  = remaining_q;
    sample_cnt_d = sample_cnt_q;
    trig_seen_d  = trig_seen_q;

    if (running) begin
      dec_cnt_d = strobe ? decim_i : dec_cnt_q - DECIM_WIDTH'(1);
    end

    if (disarm_i) begin
      state_d      = StIdle;
      dec_cnt_d    = '0;
      remaining_d  = '0;
      sample_cnt_d = '0;
      trig_seen_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm_i) begin
            // Zeroed counter makes the first ARMED cycle a strobe.
            state_d      = StArmed;
            dec_cnt_d    = '0;
            remaining_d  = '0;
            sample_cnt_d = '0;
            trig_seen_d  = 1'b0;
          end
        end
        StArmed: begin
          if (trigger_i) begin
            trig_seen_d = 1'b1;
            if (post_count_i == '0) begin
              state_d = StDone;
            end else begin
              state_d     = StPost;
              remaining_d = post_count_i;
            end
          end
        end
        StPost: begin
          if (strobe) begin
            sample_cnt_d = sample_cnt_q + CNT_WIDTH'(1);
            remaining_d  = remaining_q - CNT_WIDTH'(1);
            if (remaining_q == CNT_WIDTH'(1)) begin
              state_d = StDone;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    cap_en_d   = cap_take;
    cap_data_d = cap_take ? in : cap_data_q;
    done_d     = (state_d == StDone);
  end

  // Output decode
  always_comb begin
    running      = (state_q == StArmed) || (state_q == StPost);
    strobe       = running && (dec_cnt_q == '0);
    cap_take     = strobe && !disarm_i;
    state_o      = state_q;
    cap_en_o     = cap_en_q;
    cap_data_o   = cap_data_q;
    done_o       = done_q;
    trig_seen_o  = trig_seen_q;
    sample_cnt_o = sample_cnt_q;
  end

endmodule

// File: tb/tb_tt_dfd_capture_ctrl.sv
// Directed self-checking bench for tt_dfd_capture_ctrl.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_tt_dfd_capture_ctrl;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned CNT_WIDTH   = 8;
  localparam int unsigned DECIM_WIDTH = 4;

  logic                   clk;
  logic                   rst;
  logic                   arm;
  logic                   disarm;
  logic                   trigger;
  logic [CNT_WIDTH-1:0]   post_count;
  logic [DECIM_WIDTH-1:0] decim;
  logic [WIDTH-1:0]       din;
  logic                   cap_en;
  logic [WIDTH-1:0]       cap_data;
  logic [1:0]             state;
  logic                   done;
  logic                   trig_seen;
  logic [CNT_WIDTH-1:0]   sample_cnt;

  int checks = 0;
  int errors = 0;

  tt_dfd_capture_ctrl #(
    .WIDTH      (WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .DECIM_WIDTH(DECIM_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm_i       (arm),
    .disarm_i    (disarm),
    .trigger_i   (trigger),
    .post_count_i(post_count),
    .decim_i     (decim),
    .in          (din),
    .cap_en_o    (cap_en),
    .cap_data_o  (cap_data),
    .state_o     (state),
    .done_o      (done),
    .trig_seen_o (trig_seen),
    .sample_cnt_o(sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b1; disarm = 1'b0; trigger = 1'b1;
    post_count = 8'h05; decim = 4'h3; din = 8'h5C;
    step(); step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (cap_en !== 1'b0) begin errors++; $display("FAIL reset_cap_en got %b exp 0", cap_en); end
    checks++; if (cap_data !== 8'h00) begin errors++; $display("FAIL reset_cap_data got %h exp 00", cap_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (trig_seen !== 1'b0) begin errors++; $display("FAIL reset_trig_seen got %b exp 0", trig_seen); end
    checks++; if (sample_cnt !== 8'h00) begin errors++; $display("FAIL reset_sample_cnt got %0d exp 0", sample_cnt); end
    rst = 1'b0; arm = 1'b0; trigger = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_trig_state cyc %0d got %0d exp 0", k, state); end
      checks++; if (cap_en !== 1'b0) begin errors++; $display("FAIL idle_trig_cap_en cyc %0d got %b exp 0", k, cap_en); end
    end
    trigger = 1'b0;
  endtask

  // Arm at cycle 0, trigger at cycle 4, three post samples at cycles 5..7.
  task automatic test_basic_capture();
    logic       e_en;
    logic [1:0] e_st;
    int         e_cnt;
    decim = 4'd0; post_count = 8'd3;
    for (int k = 0; k < 10; k++) begin
      arm = (k == 0); trigger = (k == 4); din = 8'hA0 + 8'(k);
      step();
      e_en  = (k >= 1) && (k <= 7);
      e_st  = (k < 4) ? 2'd1 : (k < 7) ? 2'd2 : 2'd3;
      e_cnt = (k <= 4) ? 0 : (k >= 7) ? 3 : k - 4;
      checks++; if (cap_en !== e_en) begin errors++; $display("FAIL basic_cap_en cyc %0d got %b exp %b", k, cap_en, e_en); end
      if (e_en) begin
        checks++; if (cap_data !== 8'hA0 + 8'(k)) begin errors++; $display("FAIL basic_cap_data cyc %0d got %h exp %h", k, cap_data, 8'hA0 + 8'(k)); end
      end
      checks++; if (state !== e_st) begin errors++; $display("FAIL basic_state cyc %0d got %0d exp %0d", k, state, e_st); end
      checks++; if (sample_cnt !== 8'(e_cnt)) begin errors++; $display("FAIL basic_sample_cnt cyc %0d got %0d exp %0d", k, sample_cnt, e_cnt); end
      checks++; if (done !== (e_st == 2'd3)) begin errors++; $display("FAIL basic_done cyc %0d got %b exp %b", k, done, e_st == 2'd3); end
    end
    arm = 1'b0; trigger = 1'b0;
  endtask

  // decim=2: strobes on cycles 1,4,7,10; trigger on the cycle-4 strobe.
  task automatic test_decimation();
    logic       e_en;
    logic [1:0] e_st;
    int         e_cnt;
    decim = 4'd2; post_count = 8'd2;
    for (int k = 0; k < 14; k++) begin
      arm = (k == 0); trigger = (k == 4); din = 8'h30 + 8'(k);
      step();
      e_en  = (k == 1) || (k == 4) || (k == 7) || (k == 10);
      e_st  = (k < 4) ? 2'd1 : (k < 10) ? 2'd2 : 2'd3;
      e_cnt = (k < 7) ? 0 : (k < 10) ? 1 : 2;
      checks++; if (cap_en !== e_en) begin errors++; $display("FAIL decim_cap_en cyc %0d got %b exp %b", k, cap_en, e_en); end
      if (e_en) begin
        checks++; if (cap_data !== 8'h30 + 8'(k)) begin errors++; $display("FAIL decim_cap_data cyc %0d got %h exp %h", k, cap_data, 8'h30 + 8'(k)); end
      end
      checks++; if (state !== e_st) begin errors++; $display("FAIL decim_state cyc %0d got %0d exp %0d", k, state, e_st); end
      checks++; if (sample_cnt !== 8'(e_cnt)) begin errors++; $display("FAIL decim_sample_cnt cyc %0d got %0d exp %0d", k, sample_cnt, e_cnt); end
    end
    arm = 1'b0; trigger = 1'b0;
  endtask

  // Re-arm from DONE, then trigger with post_count=0.
  task automatic test_zero_post();
    decim = 4'd0; post_count = 8'd0;
    arm = 1'b1; step(); arm = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rearm_state got %0d exp 1", state); end
    checks++; if (trig_seen !== 1'b0) begin errors++; $display("FAIL rearm_trig_seen got %b exp 0", trig_seen); end
    checks++; if (sample_cnt !== 8'd0) begin errors++; $display("FAIL rearm_sample_cnt got %0d exp 0", sample_cnt); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rearm_done got %b exp 0", done); end
    trigger = 1'b1; din = 8'h5A; step(); trigger = 1'b0;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL zero_state got %0d exp 3", state); end
    checks++; if (cap_en !== 1'b1) begin errors++; $display("FAIL zero_cap_en got %b exp 1", cap_en); end
    checks++; if (cap_data !== 8'h5A) begin errors++; $display("FAIL zero_cap_data got %h exp 5a", cap_data); end
    checks++; if (trig_seen !== 1'b1) begin errors++; $display("FAIL zero_trig_seen got %b exp 1", trig_seen); end
    checks++; if (sample_cnt !== 8'd0) begin errors++; $display("FAIL zero_sample_cnt got %0d exp 0", sample_cnt); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done); end
    din = 8'h11; step();
    checks++; if (cap_en !== 1'b0) begin errors++; $display("FAIL zero_done_cap_en got %b exp 0", cap_en); end
  endtask

  task automatic test_abort();
    decim = 4'd0; post_count = 8'd5;
    arm = 1'b1; din = 8'h20; step(); arm = 1'b0;
    trigger = 1'b1; din = 8'h21; step(); trigger = 1'b0;
    din = 8'h22; step();
    checks++; if (sample_cnt !== 8'd1) begin errors++; $display("FAIL abort_pre_cnt got %0d exp 1", sample_cnt); end
    disarm = 1'b1; din = 8'hEE; step(); disarm = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", state); end
    checks++; if (cap_en !== 1'b0) begin errors++; $display("FAIL abort_cap_en got %b exp 0", cap_en); end
    checks++; if (cap_data !== 8'h22) begin errors++; $display("FAIL abort_cap_data_hold got %h exp 22", cap_data); end
    checks++; if (trig_seen !== 1'b0) begin errors++; $display("FAIL abort_trig_seen got %b exp 0", trig_seen); end
    checks++; if (sample_cnt !== 8'd0) begin errors++; $display("FAIL abort_sample_cnt got %0d exp 0", sample_cnt); end
    step();
    checks++; if (cap_en !== 1'b0) begin errors++; $display("FAIL abort_idle_cap_en got %b exp 0", cap_en); end
  endtask

  task automatic test_priority();
    arm = 1'b1; disarm = 1'b1; step(); disarm = 1'b0; arm = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL arm_disarm_state got %0d exp 0", state); end
    checks++; if (cap_en !== 1'b0) begin errors++; $display("FAIL arm_disarm_cap_en got %b exp 0", cap_en); end
    // arm and trigger together in IDLE: trigger is not accepted.
    decim = 4'd0; post_count = 8'd2;
    arm = 1'b1; trigger = 1'b1; step(); arm = 1'b0; trigger = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL arm_trig_state got %0d exp 1", state); end
    checks++; if (trig_seen !== 1'b0) begin errors++; $display("FAIL arm_trig_trig_seen got %b exp 0", trig_seen); end
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL arm_trig_stay_state got %0d exp 1", state); end
    trigger = 1'b1; step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL prio_post_state got %0d exp 2", state); end
    // Trigger kept high and post_count changed while in POST must not matter.
    post_count = 8'd9; step();
    checks++; if (sample_cnt !== 8'd1) begin errors++; $display("FAIL prio_post_cnt1 got %0d exp 1", sample_cnt); end
    step();
    checks++; if (sample_cnt !== 8'd2) begin errors++; $display("FAIL prio_post_cnt2 got %0d exp 2", sample_cnt); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL prio_done_state got %0d exp 3", state); end
    step(); step();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL prio_done_trig_state got %0d exp 3", state); end
    checks++; if (sample_cnt !== 8'd2) begin errors++; $display("FAIL prio_done_trig_cnt got %0d exp 2", sample_cnt); end
    checks++; if (cap_en !== 1'b0) begin errors++; $display("FAIL prio_done_trig_cap_en got %b exp 0", cap_en); end
    trigger = 1'b0;
  endtask

  task automatic test_reset_mid_capture();
    decim = 4'd0; post_count = 8'd6;
    arm = 1'b1; step(); arm = 1'b0;
    trigger = 1'b1; step(); trigger = 1'b0;
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rstmid_pre_state got %0d exp 2", state); end
    rst = 1'b1; din = 8'h77; step(); rst = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rstmid_state got %0d exp 0", state); end
    checks++; if (cap_en !== 1'b0) begin errors++; $display("FAIL rstmid_cap_en got %b exp 0", cap_en); end
    checks++; if (cap_data !== 8'h00) begin errors++; $display("FAIL rstmid_cap_data got %h exp 00", cap_data); end
    checks++; if (sample_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_sample_cnt got %0d exp 0", sample_cnt); end
    step();
    checks++; if (cap_en !== 1'b0) begin errors++; $display("FAIL rstmid_after_cap_en got %b exp 0", cap_en); end
  endtask

  task automatic test_max_count();
    int cyc;
    decim = 4'd0; post_count = 8'hFF;
    arm = 1'b1; step(); arm = 1'b0;
    trigger = 1'b1; step(); trigger = 1'b0;
    post_count = 8'd1;
    cyc = 0;
    while (state != 2'd3 && cyc < 300) begin
      step();
      cyc++;
    end
    checks++; if (cyc !== 255) begin errors++; $display("FAIL max_cycles got %0d exp 255", cyc); end
    checks++; if (sample_cnt !== 8'hFF) begin errors++; $display("FAIL max_sample_cnt got %0d exp 255", sample_cnt); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL max_done got %b exp 1", done); end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_decimation();
    test_zero_post();
    test_abort();
    test_priority();
    test_reset_mid_capture();
    test_max_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
